// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: input FIFO feeding a start/data/parity/stop framer.
// Frames queued in the FIFO leave back-to-back with no idle gap between them.
module uart_tx_param #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned UART_BPS   = 9600,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [DATA_BITS-1:0] pi_data,
    input  logic                 pi_flag,
    output logic                 tx,
    output logic                 busy,
    output logic                 fifo_full,
    output logic                 overflow
);
    localparam int unsigned BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int unsigned BW           = $clog2(BAUD_CNT_MAX);
    localparam int unsigned PW           = $clog2(FIFO_DEPTH);
    localparam int unsigned CW           = PW + 1;

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    // Reset asserts asynchronously but is released two clocks later, in step with sys_clk.
    logic [1:0] rst_sync_q;
    logic       rst_n_int;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync_q[1];

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q, count_d;
    logic                 push, pop, fifo_empty;
    logic [DATA_BITS-1:0] head;
    logic                 head_parity;

    state_e               state_q;
    logic [BW-1:0]        baud_cnt_q;
    logic [2:0]           bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 parity_q;
    logic                 baud_end, last_stop, tx_bit;

    assign fifo_empty  = (count_q == '0);
    // Fullness uses the pre-edge count, so a same-cycle pop never rescues a write.
    assign push        = pi_flag && (count_q != CW'(FIFO_DEPTH));
    assign head        = mem_q[rd_ptr_q];
    assign head_parity = (PARITY == 1) ? ~^head : ^head;

    assign baud_end  = (baud_cnt_q == BW'(BAUD_CNT_MAX - 1));
    assign last_stop = (state_q == StStop) && baud_end && (bit_cnt_q == 3'(STOP_BITS - 1));
    assign pop       = !fifo_empty && ((state_q == StIdle) || last_stop);

    always_comb begin
        count_d = count_q;
        if (push) count_d = count_d + CW'(1);
        if (pop)  count_d = count_d - CW'(1);
    end

    always_ff @(posedge sys_clk) begin
        if (push) mem_q[wr_ptr_q] <= pi_data;
    end

    always_ff @(posedge sys_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            fifo_full <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q   <= count_d;
            fifo_full <= (count_d == CW'(FIFO_DEPTH));
            overflow  <= pi_flag && !push;
        end
    end

    always_comb begin
        tx_bit = 1'b1;
        case (state_q)
            StStart:  tx_bit = 1'b0;
            StData:   tx_bit = shift_q[0];
            StParity: tx_bit = parity_q;
            default:  tx_bit = 1'b1;
        endcase
    end

    // tx and busy are registered copies of the state, so the line lags the FSM by one clock.
    always_ff @(posedge sys_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q    <= StIdle;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
        end else begin
            tx   <= tx_bit;
            busy <= (state_q != StIdle);

            if (state_q == StIdle || baud_end) begin
                baud_cnt_q <= '0;
            end else begin
                baud_cnt_q <= baud_cnt_q + BW'(1);
            end

            if (pop) begin
                shift_q  <= head;
                parity_q <= head_parity;
            end

            case (state_q)
                StIdle: begin
                    if (pop) state_q <= StStart;
                end
                StStart: begin
                    if (baud_end) begin
                        state_q   <= StData;
                        bit_cnt_q <= '0;
                    end
                end
                StData: begin
                    if (baud_end) begin
                        shift_q <= shift_q >> 1;
                        if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
                            bit_cnt_q <= '0;
                            state_q   <= (PARITY != 0) ? StParity : StStop;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end
                end
                StParity: begin
                    if (baud_end) begin
                        state_q   <= StStop;
                        bit_cnt_q <= '0;
                    end
                end
                StStop: begin
                    if (baud_end) begin
                        if (bit_cnt_q == 3'(STOP_BITS - 1)) begin
                            bit_cnt_q <= '0;
                            state_q   <= pop ? StStart : StIdle;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: several configurations side by side, expected frames queued on
// write and compared cycle by cycle against the serial line.
module tb_uart_tx_param;

    typedef struct {
        logic [15:0] bits;
        int          len;
    } frame_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] d0, d1, d2, d4;
    logic [6:0] d3;
    logic       f0, f1, f2, f3, f4;
    logic       tx0, tx1, tx2, tx3, tx4;
    logic       busy0, busy1, busy2, busy3, busy4;
    logic       full0, full1, full2, full3, full4;
    logic       ovf0, ovf1, ovf2, ovf3, ovf4;

    int     n_checks = 0;
    int     n_pass   = 0;
    frame_t sb_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx_param u_def (
        .sys_clk(clk), .sys_rst_n(rst_n), .pi_data(d0), .pi_flag(f0),
        .tx(tx0), .busy(busy0), .fifo_full(full0), .overflow(ovf0)
    );
    uart_tx_param #(.CLK_FREQ(1000), .UART_BPS(100), .PARITY(2)) u_even (
        .sys_clk(clk), .sys_rst_n(rst_n), .pi_data(d1), .pi_flag(f1),
        .tx(tx1), .busy(busy1), .fifo_full(full1), .overflow(ovf1)
    );
    uart_tx_param #(.CLK_FREQ(1000), .UART_BPS(100), .PARITY(1)) u_odd (
        .sys_clk(clk), .sys_rst_n(rst_n), .pi_data(d2), .pi_flag(f2),
        .tx(tx2), .busy(busy2), .fifo_full(full2), .overflow(ovf2)
    );
    uart_tx_param #(.CLK_FREQ(1000), .UART_BPS(100), .DATA_BITS(7), .STOP_BITS(2),
                    .PARITY(0)) u_7s2 (
        .sys_clk(clk), .sys_rst_n(rst_n), .pi_data(d3), .pi_flag(f3),
        .tx(tx3), .busy(busy3), .fifo_full(full3), .overflow(ovf3)
    );
    uart_tx_param #(.CLK_FREQ(1000), .UART_BPS(100), .FIFO_DEPTH(4)) u_p (
        .sys_clk(clk), .sys_rst_n(rst_n), .pi_data(d4), .pi_flag(f4),
        .tx(tx4), .busy(busy4), .fifo_full(full4), .overflow(ovf4)
    );

    function automatic logic tx_of(input int sel);
        case (sel)
            0: return tx0;
            1: return tx1;
            2: return tx2;
            3: return tx3;
            default: return tx4;
        endcase
    endfunction

    function automatic logic busy_of(input int sel);
        case (sel)
            0: return busy0;
            1: return busy1;
            2: return busy2;
            3: return busy3;
            default: return busy4;
        endcase
    endfunction

    // Reference frame: start 0, data LSB first, optional parity (1 odd, 2 even), stop 1s.
    function automatic frame_t make_frame(input logic [7:0] d, input int db, input int par,
                                          input int sb);
        frame_t f;
        int     k;
        logic   p;
        f.bits = '0;
        k = 1;
        p = 1'b0;
        for (int i = 0; i < db; i++) begin
            f.bits[k] = d[i];
            p = p ^ d[i];
            k++;
        end
        if (par == 1) begin
            f.bits[k] = ~p;
            k++;
        end else if (par == 2) begin
            f.bits[k] = p;
            k++;
        end
        for (int i = 0; i < sb; i++) begin
            f.bits[k] = 1'b1;
            k++;
        end
        f.len = k;
        return f;
    endfunction

    // Call at a negedge; the write is sampled at the next posedge, returns at the negedge after.
    task automatic write_word(input int sel, input logic [7:0] d);
        case (sel)
            0: begin d0 = d; f0 = 1'b1; end
            1: begin d1 = d; f1 = 1'b1; end
            2: begin d2 = d; f2 = 1'b1; end
            3: begin d3 = d[6:0]; f3 = 1'b1; end
            default: begin d4 = d; f4 = 1'b1; end
        endcase
        @(negedge clk);
        f0 = 1'b0; f1 = 1'b0; f2 = 1'b0; f3 = 1'b0; f4 = 1'b0;
    endtask

    // Waits (bounded) for a start bit, then samples every clock of an nbits-long frame.
    task automatic capture_frame(input int sel, input int m, input int nbits, input int limit,
                                 output logic [15:0] bits, output bit stable,
                                 output bit busy_hi, output int waited, output bit timed_out);
        logic v;
        bits = '0;
        stable = 1'b1;
        busy_hi = 1'b1;
        waited = 0;
        timed_out = 1'b0;
        do begin
            @(negedge clk);
            waited++;
        end while (tx_of(sel) !== 1'b0 && waited < limit);
        if (tx_of(sel) !== 1'b0) begin
            timed_out = 1'b1;
            return;
        end
        for (int i = 0; i < nbits * m; i++) begin
            if (i > 0) @(negedge clk);
            v = tx_of(sel);
            if (busy_of(sel) !== 1'b1) busy_hi = 1'b0;
            if (i % m == 0) bits[i / m] = v;
            else if (v !== bits[i / m]) stable = 1'b0;
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 5; s++) begin
            n_checks++;
            if (tx_of(s) !== 1'b1) $display("FAIL reset_tx[%0d]: got %b want 1", s, tx_of(s));
            else n_pass++;
        end
        n_checks++;
        if ({busy4, full4, ovf4} !== 3'b000)
            $display("FAIL reset_flags: busy/full/ovf got %b want 000", {busy4, full4, ovf4});
        else n_pass++;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        n_checks++;
        if ({tx4, busy4} !== 2'b10) $display("FAIL post_reset_idle: got %b want 10", {tx4, busy4});
        else n_pass++;
    endtask

    task automatic test_default();
        frame_t      e;
        logic [15:0] b;
        bit          st, bh, to, idle_ok;
        int          w;
        sb_q.push_back(make_frame(8'h35, 8, 0, 1));
        write_word(0, 8'h35);
        capture_frame(0, 5208, 10, 20, b, st, bh, w, to);
        e = sb_q.pop_front();
        n_checks++;
        if (to !== 1'b0) $display("FAIL default_timeout: got %b want 0", to);
        else n_pass++;
        n_checks++;
        if (b !== e.bits) $display("FAIL default_bits: got %h want %h", b, e.bits);
        else n_pass++;
        n_checks++;
        if ({st, bh} !== 2'b11) $display("FAIL default_bit_len_busy: got %b want 11", {st, bh});
        else n_pass++;
        idle_ok = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy0 !== 1'b0) $display("FAIL default_busy_end: got %b want 0", busy0);
        else n_pass++;
        repeat (20) begin
            if (tx0 !== 1'b1) idle_ok = 1'b0;
            @(negedge clk);
        end
        n_checks++;
        if (idle_ok !== 1'b1) $display("FAIL default_idle_high: got %b want 1", idle_ok);
        else n_pass++;
    endtask

    task automatic test_parity();
        frame_t      e;
        logic [15:0] b;
        bit          st, bh, to;
        int          w;
        for (int s = 1; s <= 2; s++) begin
            sb_q.push_back(make_frame(8'hA5, 8, (s == 1) ? 2 : 1, 1));
            write_word(s, 8'hA5);
            capture_frame(s, 10, 11, 20, b, st, bh, w, to);
            e = sb_q.pop_front();
            n_checks++;
            if (b !== e.bits || to !== 1'b0)
                $display("FAIL parity_bits[%0d]: got %h want %h (timeout %b)", s, b, e.bits, to);
            else n_pass++;
            n_checks++;
            if ({st, bh, w} !== {2'b11, 32'd2})
                $display("FAIL parity_timing[%0d]: stable/busy %b%b start %0d want 11 2",
                         s, st, bh, w);
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if (busy_of(s) !== 1'b0) $display("FAIL parity_len[%0d]: busy got 1 want 0", s);
            else n_pass++;
        end
    endtask

    task automatic test_burst();
        logic [15:0] cb[5];
        bit          cs[5], cbh[5], cto[5];
        int          cw[5];
        frame_t      e;
        int          ovf_pulses;
        ovf_pulses = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    if (i < 5) sb_q.push_back(make_frame(8'h11 + 8'(i), 8, 0, 1));
                    write_word(4, 8'h11 + 8'(i));
                    if (ovf4 === 1'b1) ovf_pulses++;
                    n_checks++;
                    if ({ovf4, full4} !== {(i == 5), (i >= 4)})
                        $display("FAIL burst_flags[%0d]: ovf/full got %b%b want %b%b", i, ovf4,
                                 full4, (i == 5), (i >= 4));
                    else n_pass++;
                end
                @(negedge clk);
                if (ovf4 === 1'b1) ovf_pulses++;
                n_checks++;
                if (ovf_pulses != 1) $display("FAIL burst_ovf_pulses: got %0d want 1", ovf_pulses);
                else n_pass++;
            end
            begin
                for (int k = 0; k < 5; k++) begin
                    logic [15:0] b;
                    bit          st, bh, to;
                    int          w;
                    capture_frame(4, 10, 10, (k == 0) ? 20 : 5, b, st, bh, w, to);
                    cb[k] = b; cs[k] = st; cbh[k] = bh; cw[k] = w; cto[k] = to;
                    if (to) break;
                end
            end
        join
        for (int k = 0; k < 5; k++) begin
            e = sb_q.pop_front();
            n_checks++;
            if (cto[k] !== 1'b0 || cb[k] !== e.bits)
                $display("FAIL burst_frame[%0d]: got %h want %h (timeout %b)", k, cb[k], e.bits,
                         cto[k]);
            else n_pass++;
            n_checks++;
            if ({cs[k], cbh[k]} !== 2'b11 || cw[k] != ((k == 0) ? 3 : 1))
                $display("FAIL burst_gap[%0d]: stable/busy %b%b start %0d want 11 %0d", k, cs[k],
                         cbh[k], cw[k], (k == 0) ? 3 : 1);
            else n_pass++;
        end
        @(negedge clk);
        n_checks++;
        if ({busy4, tx4} !== 2'b01) $display("FAIL burst_end: busy/tx got %b want 01", {busy4, tx4});
        else n_pass++;
    endtask

    task automatic test_7s2();
        logic [15:0] cb[2];
        bit          cs[2], cto[2];
        int          cw[2];
        frame_t      e;
        fork
            begin
                sb_q.push_back(make_frame(8'h7F, 7, 0, 2));
                write_word(3, 8'h7F);
                sb_q.push_back(make_frame(8'h2A, 7, 0, 2));
                write_word(3, 8'h2A);
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    logic [15:0] b;
                    bit          st, bh, to;
                    int          w;
                    capture_frame(3, 10, 10, (k == 0) ? 20 : 5, b, st, bh, w, to);
                    cb[k] = b; cs[k] = st; cw[k] = w; cto[k] = to;
                    if (to) break;
                end
            end
        join
        for (int k = 0; k < 2; k++) begin
            e = sb_q.pop_front();
            n_checks++;
            if (cto[k] !== 1'b0 || cb[k] !== e.bits || cs[k] !== 1'b1)
                $display("FAIL 7s2_frame[%0d]: got %h stable %b want %h stable 1", k, cb[k],
                         cs[k], e.bits);
            else n_pass++;
            n_checks++;
            if (cw[k] != ((k == 0) ? 3 : 1))
                $display("FAIL 7s2_start[%0d]: got %0d want %0d", k, cw[k], (k == 0) ? 3 : 1);
            else n_pass++;
        end
        @(negedge clk);
        n_checks++;
        if (busy3 !== 1'b0) $display("FAIL 7s2_busy_end: got %b want 0", busy3);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        frame_t      e;
        logic [15:0] b;
        bit          st, bh, to, quiet;
        int          w, n;
        sb_q.push_back(make_frame(8'h3C, 8, 0, 1));
        write_word(4, 8'h3C);
        sb_q.push_back(make_frame(8'hC3, 8, 0, 1));
        write_word(4, 8'hC3);
        n = 0;
        while (tx4 !== 1'b0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (tx4 !== 1'b0) $display("FAIL rstmid_start: tx got %b want 0", tx4);
        else n_pass++;
        repeat (44) @(negedge clk);
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        n_checks++;
        if ({tx4, busy4} !== 2'b10) $display("FAIL rstmid_abort: tx/busy got %b want 10",
                                             {tx4, busy4});
        else n_pass++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (300) begin
            @(negedge clk);
            if (tx4 !== 1'b1 || busy4 !== 1'b0 || full4 !== 1'b0) quiet = 1'b0;
        end
        n_checks++;
        if (quiet !== 1'b1) $display("FAIL rstmid_quiet: got %b want 1", quiet);
        else n_pass++;
        sb_q.push_back(make_frame(8'h5A, 8, 0, 1));
        write_word(4, 8'h5A);
        capture_frame(4, 10, 10, 20, b, st, bh, w, to);
        e = sb_q.pop_front();
        n_checks++;
        if (to !== 1'b0 || b !== e.bits || st !== 1'b1 || w != 2)
            $display("FAIL rstmid_new_frame: got %h start %0d want %h start 2", b, w, e.bits);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_latency();
        int n;
        write_word(4, 8'h81);
        n_checks++;
        if ({tx4, busy4} !== 2'b10) $display("FAIL lat_n: tx/busy got %b want 10", {tx4, busy4});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({tx4, busy4} !== 2'b10) $display("FAIL lat_n1: tx/busy got %b want 10", {tx4, busy4});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({tx4, busy4} !== 2'b01) $display("FAIL lat_n2: tx/busy got %b want 01", {tx4, busy4});
        else n_pass++;
        n = 0;
        while (busy4 === 1'b1 && n < 150) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n != 100) $display("FAIL lat_frame_len: got %0d want 100", n);
        else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0;
        {d0, d1, d2, d4} = '0;
        d3 = '0;
        {f0, f1, f2, f3, f4} = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_default();
        test_parity();
        test_burst();
        test_7s2();
        test_reset_mid();
        test_latency();
        n_checks++;
        if (sb_q.size() != 0) $display("FAIL scoreboard_drain: got %0d want 0", sb_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
